// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// It converts one bit per clock and has valid/ready handshakes on the input
// and the output. A sticky overflow flag is set when the value needs more
// than DIGITS digits.
// Optional macro BIN2BCD_SIGNED_EN: treat in_data as two's complement,
// convert its magnitude and report the sign on neg. When the macro is not
// defined, the input is unsigned and neg is always 0.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  neg
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state, state_nxt;
  logic [BCD_W-1:0]     bcd_sr;
  logic [BIN_W-1:0]     bin_sr;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_acc;
  logic                 neg_acc;

  logic                 accept;
  logic                 xfer;
  logic                 last_step;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_step;
  logic [BIN_W-1:0]     bin_step;
  logic                 lost;
  logic [BIN_W-1:0]     mag;
  logic                 sign;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign last_step = (state == CONV) & (cnt == CNT_W'(BIN_W - 1));

  // Sign and magnitude of the incoming value; the magnitude is unsigned, so the most negative input is exact.
  always_comb begin
`ifdef BIN2BCD_SIGNED_EN
    sign = in_data[BIN_W-1];
    mag  = sign ? ((~in_data) + BIN_W'(1)) : in_data;
`else
    sign = 1'b0;
    mag  = in_data;
`endif
  end

  // One conversion step: add 3 to each digit >= 5, then shift {bcd, bin} left; 'lost' leaves the top digit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
    {lost, bcd_step, bin_step} = {bcd_adj, bin_sr, 1'b0};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a transfer combined with an accept restarts the conversion immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CONV;
      CONV: if (last_step) state_nxt = DONE;
      DONE: if (xfer) state_nxt = accept ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, step while converting, and capture the result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_sr    <= '0;
      bin_sr    <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      neg_acc   <= 1'b0;
      out_valid <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
    end else begin
      if (accept) begin
        bcd_sr  <= '0;
        bin_sr  <= mag;
        cnt     <= '0;
        ovf_acc <= 1'b0;
        neg_acc <= sign;
      end else if (state == CONV) begin
        bcd_sr  <= bcd_step;
        bin_sr  <= bin_step;
        cnt     <= cnt + CNT_W'(1);
        ovf_acc <= ovf_acc | lost;
      end

      if (last_step) begin
        out_valid <= 1'b1;
        bcd       <= bcd_step;
        ovf       <= ovf_acc | lost;
        neg       <= neg_acc;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq. It uses a queue-based scoreboard driven by a reference model.
// Define BIN2BCD_SIGNED_EN to run the signed build with BIN_W=8.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SIGNED_EN
  localparam int unsigned TB_W = 8;
`else
  localparam int unsigned TB_W = 7;
`endif

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
    logic        neg;
  } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [TB_W-1:0] in_data;
  logic [11:0]     bcd;
  logic            ovf, neg;

  logic            in_valid2, in_ready2, out_valid2, out_ready2;
  logic [TB_W-1:0] in_data2;
  logic [7:0]      bcd2;
  logic            ovf2, neg2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_xfer = 0;
  bit   stall_on = 1'b0;
  res_t sb[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(TB_W), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .ovf(ovf), .neg(neg)
  );

  bin2bcd_seq #(.BIN_W(TB_W), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bcd(bcd2), .ovf(ovf2), .neg(neg2)
  );

  // Reference conversion: value mod 10^digits, with overflow and sign.
  function automatic res_t model(input logic [TB_W-1:0] x, input int digits);
    res_t r;
    int mag, lim, m;
    r = '0;
    mag = int'(x);
`ifdef BIN2BCD_SIGNED_EN
    if (x[TB_W-1]) begin
      r.neg = 1'b1;
      mag = (1 << TB_W) - int'(x);
    end
`endif
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r.ovf = (mag >= lim);
    m = mag % lim;
    for (int i = 0; i < digits; i++) begin
      r.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got bcd=%h with empty queue", bcd);
        end else begin
          res_t e;
          e = sb.pop_front();
          if ({bcd, ovf, neg} !== {e.bcd, e.ovf, e.neg}) begin
            n_err++;
            $display("FAIL sb_result: got bcd=%h ovf=%b neg=%b, expected bcd=%h ovf=%b neg=%b",
                     bcd, ovf, neg, e.bcd, e.ovf, e.neg);
          end
        end
        n_xfer++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, 3));
    end
  end

  // Random output back-pressure during the sweep.
  always @(posedge clk) begin
    if (stall_on) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present v until it is accepted (bounded); returns #1 after the accept edge.
  task automatic send(input logic [TB_W-1:0] v);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: value %h not accepted", v);
    end
  endtask

  // Wait (bounded) for out_valid; n = edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL wait_valid_timeout: out_valid=%b after %0d cycles", out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h want 000", bcd); end
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    if (neg !== 1'b0) begin n_err++; $display("FAIL reset_neg: got %b want 0", neg); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    int n;
    out_ready = 1'b1;
    send(TB_W'(127));
    wait_valid(n);
    n_cmp += 3;
    if (n !== int'(TB_W)) begin n_err++; $display("FAIL latency: got %0d cycles want %0d", n, TB_W); end
    if (bcd !== 12'h127) begin n_err++; $display("FAIL latency_bcd: got %h want 127", bcd); end
    if (ovf !== 1'b0) begin n_err++; $display("FAIL latency_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_values();
    logic [TB_W-1:0] vin [2];
    logic [11:0]     vexp [2];
    int n;
    vin[0] = TB_W'(0);   vexp[0] = 12'h000;
    vin[1] = TB_W'(100); vexp[1] = 12'h100;
    for (int i = 0; i < 2; i++) begin
      send(vin[i]);
      wait_valid(n);
      n_cmp++;
      if (bcd !== vexp[i]) begin n_err++; $display("FAIL value_%0d: got %h want %h", i, bcd, vexp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    send(TB_W'(42));
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp += 3;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_%0d: got %b want 1", c, out_valid); end
      if (bcd !== 12'h042) begin n_err++; $display("FAIL hold_bcd_%0d: got %h want 042", c, bcd); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready_%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    send(TB_W'(99));
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_conv: got in_ready=%b want 0", in_ready); end
    wait_valid(n);
    n_cmp += 2;
    if (n !== int'(TB_W)) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", n, TB_W); end
    if (bcd !== 12'h099) begin n_err++; $display("FAIL b2b_bcd: got %h want 099", bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [TB_W-1:0] vin [2];
    logic [7:0]      vexp [2];
    logic            oexp [2];
    int n;
    vin[0] = TB_W'(127); vexp[0] = 8'h27; oexp[0] = 1'b1;
    vin[1] = TB_W'(99);  vexp[1] = 8'h99; oexp[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid2 = 1'b1;
      in_data2  = vin[i];
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 100) begin @(posedge clk); #1; n++; end
      n_cmp += 3;
      if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL ovf_valid_%0d: got %b want 1", i, out_valid2); end
      if (bcd2 !== vexp[i]) begin n_err++; $display("FAIL ovf_bcd_%0d: got %h want %h", i, bcd2, vexp[i]); end
      if (ovf2 !== oexp[i]) begin n_err++; $display("FAIL ovf_flag_%0d: got %b want %b", i, ovf2, oexp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    bit seen;
    out_ready = 1'b1;
    send(TB_W'(127));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    if (bcd !== 12'h000) begin n_err++; $display("FAIL abort_bcd: got %h want 000", bcd); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int c = 0; c < 2 * int'(TB_W); c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result: out_valid seen=%b want 0", seen); end
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed();
    logic [TB_W-1:0] vin [3];
    logic [11:0]     vexp [3];
    logic            nexp [3];
    int n;
    out_ready = 1'b1;
    vin[0] = 8'h80; vexp[0] = 12'h128; nexp[0] = 1'b1;
    vin[1] = 8'hFF; vexp[1] = 12'h001; nexp[1] = 1'b1;
    vin[2] = 8'h7F; vexp[2] = 12'h127; nexp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(vin[i]);
      wait_valid(n);
      n_cmp += 2;
      if (bcd !== vexp[i]) begin n_err++; $display("FAIL signed_bcd_%0d: got %h want %h", i, bcd, vexp[i]); end
      if (neg !== nexp[i]) begin n_err++; $display("FAIL signed_neg_%0d: got %b want %b", i, neg, nexp[i]); end
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_sweep();
    int start, n;
    start = n_xfer;
    stall_on = 1'b1;
    for (int v = 0; v < (1 << TB_W); v++) send(TB_W'(v));
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    stall_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (n_xfer - start !== (1 << TB_W) || sb.size() != 0) begin
      n_err++;
      $display("FAIL sweep_count: got %0d results (%0d pending) want %0d", n_xfer - start, sb.size(), 1 << TB_W);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_back_to_back();
    test_overflow();
    test_abort();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
